// File: rtl/teclas_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code constants, prefix FSM
// encoding and the scan-code to ASCII translation table.
package teclas_pkg;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_LSHIFT     = 8'h12;
  localparam logic [7:0] SC_RSHIFT     = 8'h59;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } pfx_state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } xlat_t;

  // Letters are resolved first so case can be applied in one place.
  function automatic xlat_t scan_to_ascii(input logic [7:0] code,
                                          input logic       ext,
                                          input logic       upper);
    xlat_t      r;
    logic [7:0] letter;
    r      = '{hit: 1'b0, ascii: 8'h00};
    letter = 8'h00;
    if (ext) begin
      r.hit = 1'b1;
      case (code)
        8'h75:   r.ascii = 8'h10;
        8'h74:   r.ascii = 8'h11;
        8'h6B:   r.ascii = 8'h12;
        8'h72:   r.ascii = 8'h13;
        default: r.hit   = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: letter = 8'h41;
        8'h32: letter = 8'h42;
        8'h21: letter = 8'h43;
        8'h23: letter = 8'h44;
        8'h24: letter = 8'h45;
        8'h2B: letter = 8'h46;
        8'h34: letter = 8'h47;
        8'h33: letter = 8'h48;
        8'h43: letter = 8'h49;
        8'h3B: letter = 8'h4A;
        8'h42: letter = 8'h4B;
        8'h4B: letter = 8'h4C;
        8'h3A: letter = 8'h4D;
        8'h31: letter = 8'h4E;
        8'h44: letter = 8'h4F;
        8'h4D: letter = 8'h50;
        8'h15: letter = 8'h51;
        8'h2D: letter = 8'h52;
        8'h1B: letter = 8'h53;
        8'h2C: letter = 8'h54;
        8'h3C: letter = 8'h55;
        8'h2A: letter = 8'h56;
        8'h1D: letter = 8'h57;
        8'h22: letter = 8'h58;
        8'h35: letter = 8'h59;
        8'h1A: letter = 8'h5A;
        default: letter = 8'h00;
      endcase
      if (letter != 8'h00) begin
        r.hit   = 1'b1;
        r.ascii = upper ? letter : (letter | 8'h20);
      end else begin
        r.hit = 1'b1;
        case (code)
          8'h45:   r.ascii = 8'h30;
          8'h16:   r.ascii = 8'h31;
          8'h1E:   r.ascii = 8'h32;
          8'h26:   r.ascii = 8'h33;
          8'h25:   r.ascii = 8'h34;
          8'h2E:   r.ascii = 8'h35;
          8'h36:   r.ascii = 8'h36;
          8'h3D:   r.ascii = 8'h37;
          8'h3E:   r.ascii = 8'h38;
          8'h46:   r.ascii = 8'h39;
          8'h29:   r.ascii = 8'h20;
          8'h0E:   r.ascii = 8'h60;
          8'h4E:   r.ascii = 8'h2D;
          8'h55:   r.ascii = 8'h3D;
          8'h54:   r.ascii = 8'h5B;
          8'h5B:   r.ascii = 8'h5D;
          8'h5D:   r.ascii = 8'h5C;
          8'h4C:   r.ascii = 8'h3B;
          8'h52:   r.ascii = 8'h27;
          8'h41:   r.ascii = 8'h2C;
          8'h49:   r.ascii = 8'h2E;
          8'h4A:   r.ascii = 8'h2F;
          8'h5A:   r.ascii = 8'h0D;
          8'h66:   r.ascii = 8'h08;
          8'h05:   r.ascii = 8'h20;
          8'h06:   r.ascii = 8'h21;
          8'h04:   r.ascii = 8'h22;
          8'h0C:   r.ascii = 8'h23;
          8'h03:   r.ascii = 8'h25;
          8'h0B:   r.ascii = 8'h26;
          8'h83:   r.ascii = 8'h27;
          8'h0A:   r.ascii = 8'h28;
          default: r.hit   = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo_sync.sv
// Single-clock DEPTH-entry FIFO with occupancy count, show-ahead head output
// and simultaneous push/pop (push accepted when full only if a pop happens).
module key_fifo_sync #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == FULL_CNT);
    end
  end

  // Storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/key_decoder_fifo.sv
// PS/2 scan-code decoder: prefix FSM, shift and held-key tracking, ASCII
// translation with typematic filter, queued into a show-ahead FIFO with IRQ.
module key_decoder_fifo
  import teclas_pkg::*;
#(
  parameter  int unsigned DEPTH       = 8,
  parameter  bit          CASE_MODE   = 1'b0,
  parameter  bit          REPEAT_EN   = 1'b0,
  parameter  bit          MAP_UNKNOWN = 1'b1,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          code_valid,
  input  logic [7:0]    code_in,
  input  logic          rd_en,
  input  logic          stop,
  output logic [7:0]    ascii_out,
  output logic [7:0]    key_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          interrupt,
  output logic          overflow
);

  pfx_state_e state_q, state_d;
  logic       shift_q, shift_d;
  logic [8:0] held_q, held_d;
  logic [7:0] key_q, key_d;
  logic       int_q, int_d;
  logic       ovf_q, ovf_d;

  logic       is_make, is_break, cur_ext;
  logic [8:0] cur_key;
  logic       is_shift, repeat_hit, upper;
  xlat_t      xl;
  logic       want_push, push_ok, ovf_ev;
  logic [7:0] push_data;
  logic       fifo_full;

  // Prefix FSM: classifies each received byte as make, break or prefix.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    cur_ext  = 1'b0;
    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code_in == SC_EXT)      state_d = ST_EXT;
          else if (code_in == SC_BRK) state_d = ST_BRK;
          else                        is_make = 1'b1;
        end
        ST_EXT: begin
          if (code_in == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            is_make = 1'b1;
            cur_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_break = 1'b1;
          cur_ext  = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cur_key    = {cur_ext, code_in};
  assign is_shift   = !cur_ext && ((code_in == SC_LSHIFT) || (code_in == SC_RSHIFT));
  assign repeat_hit = !REPEAT_EN && (held_q != 9'h000) && (held_q == cur_key);
  assign upper      = !CASE_MODE || shift_q;
  assign xl         = scan_to_ascii(code_in, cur_ext, upper);
  assign push_data  = xl.hit ? xl.ascii : ASCII_UNKNOWN;

  // Shift/held/key bookkeeping and the decision to queue a translated make.
  always_comb begin
    shift_d   = shift_q;
    held_d    = held_q;
    key_d     = key_q;
    want_push = 1'b0;
    if (is_break) begin
      if (is_shift)          shift_d = 1'b0;
      if (held_q == cur_key) held_d  = 9'h000;
    end else if (is_make) begin
      if (is_shift) begin
        shift_d = 1'b1;
      end else if (!repeat_hit) begin
        held_d    = cur_key;
        key_d     = code_in;
        want_push = xl.hit || (MAP_UNKNOWN && !cur_ext);
      end
    end
  end

  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign push_ok = want_push && (!fifo_full || rd_en);
  assign ovf_ev  = want_push && fifo_full && !rd_en;
  assign int_d   = (int_q && !stop) || push_ok;
  assign ovf_d   = (ovf_q && !stop) || ovf_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
      held_q  <= 9'h000;
      key_q   <= 8'h00;
      int_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      held_q  <= held_d;
      key_q   <= key_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
    end
  end

  key_fifo_sync #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (want_push),
    .wdata (push_data),
    .pop   (rd_en),
    .rdata (ascii_out),
    .empty (empty),
    .full  (fifo_full),
    .count (count)
  );

  assign full      = fifo_full;
  assign key_out   = key_q;
  assign interrupt = int_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_decoder_fifo.sv
// Bench for key_decoder_fifo: two configurations share one stimulus stream and
// are checked every cycle against a queue-based behavioural model.
module tb_key_decoder_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       stop = 1'b0;

  logic [7:0] a0, k0, a1, k1;
  logic       e0, f0, i0, v0, e1, f1, i1, v1;
  logic [3:0] c0;
  logic [2:0] c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: DEPTH 8, uppercase, repeat filter on, unknown -> '*'
  key_decoder_fifo #(.DEPTH(8), .CASE_MODE(1'b0), .REPEAT_EN(1'b0), .MAP_UNKNOWN(1'b1)) u0 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_in(code_in), .rd_en(rd_en),
    .stop(stop), .ascii_out(a0), .key_out(k0), .empty(e0), .full(f0), .count(c0),
    .interrupt(i0), .overflow(v0));

  // u1: DEPTH 4, shift-aware case, repeats queued, unknown dropped
  key_decoder_fifo #(.DEPTH(4), .CASE_MODE(1'b1), .REPEAT_EN(1'b1), .MAP_UNKNOWN(1'b0)) u1 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_in(code_in), .rd_en(rd_en),
    .stop(stop), .ascii_out(a1), .key_out(k1), .empty(e1), .full(f1), .count(c1),
    .interrupt(i1), .overflow(v1));

  // ---------------- reference model ----------------
  logic [7:0] t_let [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] t_dig [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] t_pc  [22] = '{8'h29,8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,
                             8'h4A,8'h5A,8'h66,8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A};
  logic [7:0] t_pa  [22] = '{8'h20,8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,
                             8'h2F,8'h0D,8'h08,8'h20,8'h21,8'h22,8'h23,8'h25,8'h26,8'h27,8'h28};
  logic [7:0] t_ext [4]  = '{8'h75,8'h74,8'h6B,8'h72};
  logic [7:0] pool  [16] = '{8'hE0,8'hF0,8'h12,8'h59,8'h1C,8'h32,8'h75,8'h74,
                             8'h6B,8'h72,8'h45,8'h5A,8'h66,8'h83,8'h7D,8'hE0};

  logic       m_pe [2];
  logic       m_pb [2];
  logic       m_sh [2];
  logic       m_int [2];
  logic       m_ovf [2];
  logic [8:0] m_held [2];
  logic [7:0] m_key [2];
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];

  function automatic int  pdep (input int i); return (i == 0) ? 8 : 4; endfunction
  function automatic bit  pcase(input int i); return (i == 1);        endfunction
  function automatic bit  prep (input int i); return (i == 1);        endfunction
  function automatic bit  pmap (input int i); return (i == 0);        endfunction

  function automatic int msize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] mhead(input int i);
    if (msize(i) == 0) return 8'h00;
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic void xl_model(input logic [7:0] c, input logic ext, input logic up,
                                   output logic hit, output logic [7:0] val);
    hit = 1'b0;
    val = 8'h00;
    if (ext) begin
      for (int k = 0; k < 4; k++)
        if (t_ext[k] == c) begin hit = 1'b1; val = 8'h10 + 8'(k); end
    end else begin
      for (int k = 0; k < 26; k++)
        if (t_let[k] == c) begin hit = 1'b1; val = (up ? 8'h41 : 8'h61) + 8'(k); end
      for (int k = 0; k < 10; k++)
        if (t_dig[k] == c) begin hit = 1'b1; val = 8'h30 + 8'(k); end
      for (int k = 0; k < 22; k++)
        if (t_pc[k] == c) begin hit = 1'b1; val = t_pa[k]; end
    end
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_pe[i] = 1'b0; m_pb[i] = 1'b0; m_sh[i] = 1'b0;
      m_int[i] = 1'b0; m_ovf[i] = 1'b0; m_held[i] = 9'h000; m_key[i] = 8'h00;
    end
    mq0.delete();
    mq1.delete();
  endtask

  task automatic mstep(input int i);
    logic ext, brk, hit, pushed, ovfev, popping, is_sh;
    logic [7:0] val;
    int sz;
    hit = 1'b0; val = 8'h00; pushed = 1'b0; ovfev = 1'b0;
    sz = msize(i);
    if (code_valid) begin
      if (!m_pb[i] && !m_pe[i] && code_in == 8'hE0) m_pe[i] = 1'b1;
      else if (!m_pb[i] && code_in == 8'hF0)        m_pb[i] = 1'b1;
      else begin
        ext = m_pe[i]; brk = m_pb[i];
        m_pe[i] = 1'b0; m_pb[i] = 1'b0;
        is_sh = !ext && (code_in == 8'h12 || code_in == 8'h59);
        if (brk) begin
          if (is_sh) m_sh[i] = 1'b0;
          if (m_held[i] == {ext, code_in}) m_held[i] = 9'h000;
        end else if (is_sh) begin
          m_sh[i] = 1'b1;
        end else if (prep(i) || m_held[i] == 9'h000 || m_held[i] != {ext, code_in}) begin
          m_held[i] = {ext, code_in};
          m_key[i]  = code_in;
          xl_model(code_in, ext, !pcase(i) || m_sh[i], hit, val);
          if (!hit && !ext && pmap(i)) begin hit = 1'b1; val = 8'h2A; end
        end
      end
    end
    popping = rd_en && (sz > 0);
    if (hit) begin
      if (sz == pdep(i) && !popping) ovfev = 1'b1;
      else pushed = 1'b1;
    end
    if (popping) begin
      if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (pushed) begin
      if (i == 0) mq0.push_back(val); else mq1.push_back(val);
    end
    if (stop)   begin m_int[i] = 1'b0; m_ovf[i] = 1'b0; end
    if (pushed) m_int[i] = 1'b1;
    if (ovfev)  m_ovf[i] = 1'b1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mreset();
    else for (int i = 0; i < 2; i++) mstep(i);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("u0 ascii_out", 32'(a0), 32'(mhead(0)));
    chk("u0 count",     32'(c0), 32'(msize(0)));
    chk("u0 empty",     32'(e0), 32'(msize(0) == 0));
    chk("u0 full",      32'(f0), 32'(msize(0) == 8));
    chk("u0 key_out",   32'(k0), 32'(m_key[0]));
    chk("u0 interrupt", 32'(i0), 32'(m_int[0]));
    chk("u0 overflow",  32'(v0), 32'(m_ovf[0]));
    chk("u1 ascii_out", 32'(a1), 32'(mhead(1)));
    chk("u1 count",     32'(c1), 32'(msize(1)));
    chk("u1 empty",     32'(e1), 32'(msize(1) == 0));
    chk("u1 full",      32'(f1), 32'(msize(1) == 4));
    chk("u1 key_out",   32'(k1), 32'(m_key[1]));
    chk("u1 interrupt", 32'(i1), 32'(m_int[1]));
    chk("u1 overflow",  32'(v1), 32'(m_ovf[1]));
  end

  // ---------------- stimulus (all tasks start and end on a falling edge) ----------------
  task automatic send(input logic [7:0] b);
    code_valid = 1'b1; code_in = b;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [], input int n);
    for (int k = 0; k < n; k++) send(s[k]);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic flush();
    rd_en = 1'b1; repeat (9) @(negedge clk); rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] s [];
    repeat (3) @(negedge clk);
    chk("reset ascii_out", 32'(a0), 32'h00);
    chk("reset count",     32'(c0), 32'h0);
    chk("reset empty",     32'(e0), 32'h1);
    chk("reset full",      32'(f1), 32'h0);
    chk("reset interrupt", 32'(i0), 32'h0);
    chk("reset key_out",   32'(k0), 32'h00);
    rst = 1'b1;
    @(negedge clk);

    // make / break / stop
    send(8'h1C);
    chk("irq after make", 32'(i0), 32'h1);
    chk("count after make", 32'(c0), 32'h1);
    send(8'hF0); send(8'h1C);
    chk("u0 head A", 32'(a0), 32'h41);
    chk("u1 head a", 32'(a1), 32'h61);
    chk("u0 key_out 1C", 32'(k0), 32'h1C);
    send(8'h1C);
    chk("held cleared by break", 32'(c0), 32'h2);
    pulse_stop();
    chk("irq cleared by stop", 32'(i0), 32'h0);
    flush(); send(8'hF0); send(8'h1C);

    // shift-aware case
    s = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    send_seq(s, 7);
    chk("case u1 count", 32'(c1), 32'h2);
    chk("case u1 first", 32'(a1), 32'h41);
    pop1();
    chk("case u1 second", 32'(a1), 32'h61);
    flush(); send(8'hF0); send(8'h1C);

    // extended codes
    s = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h7D};
    send_seq(s, 7);
    chk("ext count", 32'(c0), 32'h1);
    chk("ext head",  32'(a0), 32'h10);
    send(8'h1C);
    chk("idle after ext", 32'(c0), 32'h2);
    flush(); send(8'hF0); send(8'h1C);

    // typematic repeat filter
    s = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    send_seq(s, 6);
    chk("repeat filtered", 32'(c0), 32'h2);
    chk("repeat kept",     32'(c1), 32'h4);
    flush(); send(8'hF0); send(8'h1C);

    // overflow on the DEPTH-4 instance, then pop+push while full
    s = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    send_seq(s, 5);
    chk("ovf full",     32'(f1), 32'h1);
    chk("ovf count",    32'(c1), 32'h4);
    chk("ovf flag",     32'(v1), 32'h1);
    chk("ovf head",     32'(a1), 32'h61);
    chk("u0 five",      32'(c0), 32'h5);
    rd_en = 1'b1; send(8'h2B); rd_en = 1'b0;
    chk("pp count",     32'(c1), 32'h4);
    chk("pp ovf held",  32'(v1), 32'h1);
    chk("pp head",      32'(a1), 32'h62);
    pulse_stop();
    chk("ovf cleared",  32'(v1), 32'h0);
    flush(); send(8'hF0); send(8'h2B);

    // reset between prefix and code
    send(8'hE0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst count", 32'(c0), 32'h0);
    chk("midrst empty", 32'(e0), 32'h1);
    chk("midrst key",   32'(k0), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'h75);
    chk("post-rst unknown", 32'(a0), 32'h2A);
    chk("post-rst u1 drop", 32'(c1), 32'h0);
    flush();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      code_valid = ($urandom_range(0, 2) == 0);
      code_in    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      rd_en      = ($urandom_range(0, 99) < (((n / 400) % 2) ? 60 : 12));
      stop       = ($urandom_range(0, 39) == 0);
      if (n == 1500 || n == 3100) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    code_valid = 1'b0; rd_en = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
